av_counter_updn: RTL and testbench
==================================

# av_counter_updn

Parametrised synchronous binary up/down counter cell for the Fujitsu AV cell library. It generalises the 4-bit up counter with load, clear, enable and carry chain to WIDTH bits. It adds count direction, a runtime terminal value (modulo), a stop-at-terminal one-shot mode, and registered terminal-count and done flags. It is used in video timing and sprite address generation wherever chained 4-bit counters plus glue logic were needed before.

## Interface
- WIDTH, 4: counter width in bits, 1..16.
- INIT, 0: value of Q after async clear, WIDTH bits.

- CK  in  1  clock, all state changes on rising edge.
- nCL  in  1  asynchronous active-low reset/clear, dominant over everything.
- D  in  WIDTH  parallel load data.
- nL  in  1  synchronous active-low load.
- nSC  in  1  synchronous active-low clear to 0.
- EN  in  1  count enable.
- CI  in  1  carry/borrow in for cascading, ANDed with EN.
- UP  in  1  direction: 1 counts up, 0 counts down.
- LIM  in  WIDTH  terminal value: the up-count wraps LIM→0, the down-count wraps 0→LIM.
- MODE  in  1  0 = wrap, 1 = stop at terminal (one-shot).
- Q  out  WIDTH  count value.
- CO  out  1  combinational carry out: CI & (UP ? Q==LIM : Q==0). It does not depend on EN or DONE.
- TC  out  1  registered one-cycle terminal-count pulse.
- DONE  out  1  registered sticky flag, set when stop mode reaches terminal.

## Operation
- Reset (nCL=0, asynchronous): Q=INIT, TC=0, DONE=0, held while nCL low.
- Priority per rising CK edge: nL load > nSC clear > count > hold.
- Load: Q=D, DONE=0, TC=0.
- Sync clear: Q=0, DONE=0, TC=0.
- Step qualified when EN & CI & ~DONE.
- Terminal condition T = UP ? (Q==LIM) : (Q==0).
- Qualified step, MODE=0:
  - If T: Q wraps (up: 0; down: LIM) and TC=1.
  - Otherwise Q=Q±1, modulo 2^WIDTH.
- Qualified step, MODE=1:
  - If T: Q holds, DONE=1, TC=1.
  - Otherwise Q=Q±1.
- DONE=1 blocks further steps until load, sync clear or nCL. CO still reflects Q and CI.
- TC is 0 in every cycle that is not a terminal step. There is no back-to-back TC in stop mode.
- Out-of-range values, Q>LIM (e.g. after load):
  - Up: increments normally, passes 2^WIDTH-1→0, then reaches LIM.
  - Down: decrements to 0, then wraps to LIM.
- LIM=0: up mode holds Q=0 with TC every qualified cycle (MODE=0). Down mode behaves the same.
- UP, LIM and MODE may change on any cycle; the value sampled at the edge applies.
- Cascade: the CO of a stage drives the CI of the next stage. All stages share EN, UP and LIM slices. LIM per stage equals the stage's slice of the full terminal value, so cascading is only exact for LIM = all-ones/zero per stage. This is documented, not corrected.

## Timing
- Q, TC, DONE: registered, one CK edge after a qualified input.
- CO: combinational from Q, CI, UP, LIM, valid within the same cycle. No inserted delays in synthesis. The sim cell model keeps the library's delay convention: clock-to-Q #1 on count, #3 on CO.
- TC rises on the edge that performs the terminal step and falls on the next edge unless another terminal step occurs.
- nCL release: the first edge with nCL=1 may already load or count.
- nCL asserted mid-count: Q goes to INIT immediately, independent of CK. A pending TC or DONE is lost.

## Structure
- Shared package av_cells_pkg: direction constants DIR_UP=1, DIR_DN=0; mode constants MODE_WRAP=0, MODE_STOP=1.
- One combinational sub-module, av_cnt_next: computes next Q, T and the terminal-step flag from Q, LIM, UP, MODE. The top module holds the registers, priority and the CO assign.
- WIDTH=4, INIT=0, MODE=0, UP=1, LIM=15 must be cycle-equivalent to the existing 4-bit up counter cell.

## Test plan
- Async reset: with INIT=5 and WIDTH=4, pulse nCL low mid-cycle. Q=5 immediately, and TC=0, DONE=0.
- Up wrap: LIM=9, Q=0, EN=CI=1, 10 edges. Q runs 1..9. Edge 10 gives Q=0, TC=1 for one cycle. CO=1 while Q=9.
- Down wrap: UP=0, LIM=12, load 1. Edges give Q=0, then Q=12 with TC=1. CO=1 while Q=0.
- Stop mode: MODE=1, LIM=3, Q=0, 5 edges. Q=1,2,3,3,3, DONE=1 from edge 4. TC is high only after edge 4. Asserting nL with D=2 gives Q=2, DONE=0.
- Priority: nL=0 and nSC=0 together with EN=CI=1 and D=7 give Q=7. nSC=0 alone gives Q=0. EN=1 with CI=0 holds Q.
- Out-of-range and cascade: WIDTH=4, LIM=5, load 14, count up. Q runs 15, 0 (no TC), 1..5, then wraps with TC. A second bench chains two WIDTH=4 instances, each with LIM=15, so 255 counts ripple to 0 with the upper CO=1 at 255.

Source files
------------

// File: rtl/av_cells_pkg.sv
// av_cells_pkg: direction and mode encodings shared by the AV counter cells
package av_cells_pkg;
  localparam logic DIR_UP    = 1'b1;
  localparam logic DIR_DN    = 1'b0;
  localparam logic MODE_WRAP = 1'b0;
  localparam logic MODE_STOP = 1'b1;
endpackage

// File: rtl/av_cnt_next.sv
// av_cnt_next: next-count, terminal detect and stop-hit for the up/down counter
module av_cnt_next
  import av_cells_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic [WIDTH-1:0] q,
  input  logic [WIDTH-1:0] lim,
  input  logic             up,
  input  logic             mode,
  output logic [WIDTH-1:0] q_nxt,
  output logic             t,
  output logic             stop
);
  logic [WIDTH-1:0] wrap_q;
  assign t      = (up == DIR_UP) ? (q == lim) : (q == '0);
  assign stop   = t & (mode == MODE_STOP);
  assign wrap_q = (up == DIR_UP) ? '0 : lim;
  // out-of-range values simply roll through 2^WIDTH until they meet LIM or 0
  assign q_nxt  = stop ? q : t ? wrap_q : (up == DIR_UP) ? q + WIDTH'(1) : q - WIDTH'(1);
endmodule

// File: rtl/av_counter_updn.sv
// av_counter_updn: WIDTH-bit up/down counter with load, clear, modulo LIM and one-shot stop
module av_counter_updn
  import av_cells_pkg::*;
#(
  parameter int               WIDTH = 4,
  parameter logic [WIDTH-1:0] INIT  = '0
) (
  input  logic             CK,
  input  logic             nCL,
  input  logic [WIDTH-1:0] D,
  input  logic             nL,
  input  logic             nSC,
  input  logic             EN,
  input  logic             CI,
  input  logic             UP,
  input  logic [WIDTH-1:0] LIM,
  input  logic             MODE,
  output logic [WIDTH-1:0] Q,
  output logic             CO,
  output logic             TC,
  output logic             DONE
);
  logic [WIDTH-1:0] q_nxt;
  logic             t, stop, step;
  av_cnt_next #(.WIDTH(WIDTH)) u_next (
    .q(Q), .lim(LIM), .up(UP), .mode(MODE), .q_nxt(q_nxt), .t(t), .stop(stop)
  );
  assign step = EN & CI & ~DONE;
  assign CO   = CI & t;
  always_ff @(posedge CK or negedge nCL) begin
    if (!nCL) begin
      Q    <= INIT;
      TC   <= 1'b0;
      DONE <= 1'b0;
    end else if (!nL) begin
      Q    <= D;
      TC   <= 1'b0;
      DONE <= 1'b0;
    end else if (!nSC) begin
      Q    <= '0;
      TC   <= 1'b0;
      DONE <= 1'b0;
    end else if (step) begin
      Q    <= q_nxt;
      TC   <= t;
      DONE <= stop;
    end else begin
      TC   <= 1'b0;
    end
  end
endmodule

// File: tb/tb_av_counter_updn.sv
// tb_av_counter_updn: directed checks of the up/down counter and a two-stage cascade
module tb_av_counter_updn;
  logic       CK = 1'b0;
  logic       nCL, nL, nSC, EN, CI, UP, MODE;
  logic [3:0] D, LIM, Q;
  logic       CO, TC, DONE;
  logic       c_nsc, c_en, c_ci;
  logic [3:0] lo_q, hi_q;
  logic       lo_co, hi_co, lo_tc, hi_tc, lo_done, hi_done;
  int total = 0;
  int bad = 0;

  always #5 CK = ~CK;

  av_counter_updn #(.WIDTH(4), .INIT(4'd5)) dut (
    .CK(CK), .nCL(nCL), .D(D), .nL(nL), .nSC(nSC), .EN(EN), .CI(CI), .UP(UP),
    .LIM(LIM), .MODE(MODE), .Q(Q), .CO(CO), .TC(TC), .DONE(DONE)
  );
  av_counter_updn #(.WIDTH(4), .INIT(4'd0)) u_lo (
    .CK(CK), .nCL(nCL), .D(4'd0), .nL(1'b1), .nSC(c_nsc), .EN(c_en), .CI(c_ci), .UP(1'b1),
    .LIM(4'd15), .MODE(1'b0), .Q(lo_q), .CO(lo_co), .TC(lo_tc), .DONE(lo_done)
  );
  av_counter_updn #(.WIDTH(4), .INIT(4'd0)) u_hi (
    .CK(CK), .nCL(nCL), .D(4'd0), .nL(1'b1), .nSC(c_nsc), .EN(c_en), .CI(lo_co), .UP(1'b1),
    .LIM(4'd15), .MODE(1'b0), .Q(hi_q), .CO(hi_co), .TC(hi_tc), .DONE(hi_done)
  );

  task automatic tick;
    @(posedge CK);
    #1;
  endtask

  task automatic test_reset;
    nCL = 1'b0; nL = 1'b1; nSC = 1'b1; EN = 1'b0; CI = 1'b0; UP = 1'b1;
    MODE = 1'b0; D = 4'd0; LIM = 4'd15; c_nsc = 1'b1; c_en = 1'b0; c_ci = 1'b0;
    #12;
    total++; if (Q !== 4'd5) begin bad++; $display("FAIL reset_q: got %0d want 5", Q); end
    total++; if ({TC, DONE} !== 2'b00) begin bad++; $display("FAIL reset_flags: got %b want 00", {TC, DONE}); end
    tick();
    nCL = 1'b1; nL = 1'b0; D = 4'd3;
    tick();
    nL = 1'b1;
    total++; if (Q !== 4'd3) begin bad++; $display("FAIL reset_release_load: got %0d want 3", Q); end
    #2 nCL = 1'b0;
    #1;
    total++; if (Q !== 4'd5) begin bad++; $display("FAIL reset_async: got %0d want 5", Q); end
    total++; if ({TC, DONE} !== 2'b00) begin bad++; $display("FAIL reset_async_flags: got %b want 00", {TC, DONE}); end
    nCL = 1'b1;
    tick();
  endtask

  task automatic test_up_wrap;
    UP = 1'b1; MODE = 1'b0; LIM = 4'd9; nSC = 1'b0;
    tick();
    nSC = 1'b1;
    total++; if (Q !== 4'd0) begin bad++; $display("FAIL up_clear: got %0d want 0", Q); end
    EN = 1'b1; CI = 1'b1;
    for (int i = 1; i <= 9; i++) begin
      tick();
      total++; if (Q !== 4'(i) || TC !== 1'b0) begin bad++; $display("FAIL up_q%0d: got q=%0d tc=%b want q=%0d tc=0", i, Q, TC, i); end
      total++; if (CO !== (i == 9)) begin bad++; $display("FAIL up_co%0d: got %b want %b", i, CO, i == 9); end
    end
    tick();
    total++; if (Q !== 4'd0 || TC !== 1'b1) begin bad++; $display("FAIL up_wrap: got q=%0d tc=%b want q=0 tc=1", Q, TC); end
    tick();
    total++; if (Q !== 4'd1 || TC !== 1'b0) begin bad++; $display("FAIL up_after: got q=%0d tc=%b want q=1 tc=0", Q, TC); end
    EN = 1'b0;
  endtask

  task automatic test_down_wrap;
    UP = 1'b0; LIM = 4'd12; nL = 1'b0; D = 4'd1;
    tick();
    nL = 1'b1;
    total++; if (Q !== 4'd1 || CO !== 1'b0) begin bad++; $display("FAIL dn_load: got q=%0d co=%b want q=1 co=0", Q, CO); end
    EN = 1'b1; CI = 1'b1;
    tick();
    total++; if (Q !== 4'd0 || TC !== 1'b0 || CO !== 1'b1) begin bad++; $display("FAIL dn_zero: got q=%0d tc=%b co=%b want 0/0/1", Q, TC, CO); end
    tick();
    total++; if (Q !== 4'd12 || TC !== 1'b1 || CO !== 1'b0) begin bad++; $display("FAIL dn_wrap: got q=%0d tc=%b co=%b want 12/1/0", Q, TC, CO); end
    tick();
    total++; if (Q !== 4'd11 || TC !== 1'b0) begin bad++; $display("FAIL dn_next: got q=%0d tc=%b want 11/0", Q, TC); end
    EN = 1'b0;
  endtask

  task automatic test_stop;
    logic [3:0] eq [5] = '{4'd1, 4'd2, 4'd3, 4'd3, 4'd3};
    logic       et [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0};
    logic       ed [5] = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b1};
    UP = 1'b1; MODE = 1'b1; LIM = 4'd3; nSC = 1'b0;
    tick();
    nSC = 1'b1; EN = 1'b1; CI = 1'b1;
    for (int i = 0; i < 5; i++) begin
      tick();
      total++; if (Q !== eq[i] || TC !== et[i] || DONE !== ed[i]) begin bad++; $display("FAIL stop_e%0d: got q=%0d tc=%b done=%b want q=%0d tc=%b done=%b", i + 1, Q, TC, DONE, eq[i], et[i], ed[i]); end
    end
    total++; if (CO !== 1'b1) begin bad++; $display("FAIL stop_co: got %b want 1", CO); end
    nL = 1'b0; D = 4'd2;
    tick();
    nL = 1'b1;
    total++; if (Q !== 4'd2 || DONE !== 1'b0) begin bad++; $display("FAIL stop_reload: got q=%0d done=%b want q=2 done=0", Q, DONE); end
    EN = 1'b0; MODE = 1'b0;
  endtask

  task automatic test_priority;
    UP = 1'b1; LIM = 4'd15; EN = 1'b1; CI = 1'b1; nL = 1'b0; nSC = 1'b0; D = 4'd7;
    tick();
    total++; if (Q !== 4'd7) begin bad++; $display("FAIL prio_load: got %0d want 7", Q); end
    nL = 1'b1; nSC = 1'b1; CI = 1'b0;
    tick();
    total++; if (Q !== 4'd7 || TC !== 1'b0) begin bad++; $display("FAIL prio_ci_hold: got q=%0d tc=%b want 7/0", Q, TC); end
    CI = 1'b1; nSC = 1'b0;
    tick();
    nSC = 1'b1;
    total++; if (Q !== 4'd0) begin bad++; $display("FAIL prio_clear: got %0d want 0", Q); end
    EN = 1'b0;
  endtask

  task automatic test_out_of_range;
    logic [3:0] eq [8] = '{4'd15, 4'd0, 4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd0};
    UP = 1'b1; MODE = 1'b0; LIM = 4'd5; nL = 1'b0; D = 4'd14;
    tick();
    nL = 1'b1; EN = 1'b1; CI = 1'b1;
    for (int i = 0; i < 8; i++) begin
      tick();
      total++; if (Q !== eq[i] || TC !== (i == 7)) begin bad++; $display("FAIL oor_e%0d: got q=%0d tc=%b want q=%0d tc=%b", i + 1, Q, TC, eq[i], i == 7); end
    end
    LIM = 4'd0;
    for (int i = 0; i < 2; i++) begin
      tick();
      total++; if (Q !== 4'd0 || TC !== 1'b1) begin bad++; $display("FAIL lim0_e%0d: got q=%0d tc=%b want 0/1", i + 1, Q, TC); end
    end
    EN = 1'b0;
  endtask

  task automatic test_cascade;
    c_nsc = 1'b0;
    tick();
    c_nsc = 1'b1; c_en = 1'b1; c_ci = 1'b1;
    for (int i = 1; i <= 255; i++) begin
      tick();
      total++; if ({hi_q, lo_q} !== 8'(i)) begin bad++; $display("FAIL casc_%0d: got %0d want %0d", i, {hi_q, lo_q}, i); end
    end
    total++; if (hi_co !== 1'b1) begin bad++; $display("FAIL casc_co255: got %b want 1", hi_co); end
    tick();
    total++; if ({hi_q, lo_q} !== 8'd0 || hi_tc !== 1'b1 || hi_co !== 1'b0) begin bad++; $display("FAIL casc_wrap: got q=%0d tc=%b co=%b want 0/1/0", {hi_q, lo_q}, hi_tc, hi_co); end
    c_en = 1'b0;
  endtask

  initial begin
    test_reset();
    test_up_wrap();
    test_down_wrap();
    test_stop();
    test_priority();
    test_out_of_range();
    test_cascade();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
